// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game sequencing controller.
package game_flow_pkg;

    localparam int FRAME_CNT_W = 8;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        START_PAGE = 3'd1,
        GAME_ON    = 3'd2,
        PAUSED     = 3'd3,
        GO_SHOW    = 3'd4,
        GO_HIDE    = 3'd5
    } game_flow_e;

endpackage

// File: rtl/game_flow_ctrl_frame_down_counter.sv
// Loadable frame down-counter that saturates at zero; load beats enable.
module frame_down_counter #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         is_one,
    output logic         is_zero
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one  = (count == W'(1));
    assign is_zero = (count == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencing FSM: init, start page, play, pause and a blinking game-over
// window timed in VGA frames; latches the surviving player as the winner.
module game_flow_ctrl
    import game_flow_pkg::*;
#(
    parameter int NUM_PLAYERS      = 2,
    parameter int LIFE_W           = 4,
    parameter int CNT_W            = FRAME_CNT_W,
    parameter int GAMEOVER_FRAMES  = 160,
    parameter int BLINK_ON_FRAMES  = 16,
    parameter int BLINK_OFF_FRAMES = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          VGA_VS,
    input  logic                          load_finish,
    input  logic                          start,
    input  logic                          restart,
    input  logic                          pause_req,
    input  logic [NUM_PLAYERS*LIFE_W-1:0] player_lives,
    output logic                          display_init,
    output logic                          load_startpage,
    output logic                          load_map,
    output logic                          game_on,
    output logic                          paused,
    output logic                          game_over,
    output logic                          draw_gameover,
    output logic                          draw_cursor,
    output logic [NUM_PLAYERS-1:0]        winner_onehot,
    output logic [CNT_W-1:0]              frame_counter,
    output game_flow_e                    flow_state
);

    localparam int ALIVE_W = $clog2(NUM_PLAYERS + 1);
    localparam logic [CNT_W-1:0] GO_VAL  = CNT_W'(GAMEOVER_FRAMES);
    localparam logic [CNT_W-1:0] ON_VAL  = CNT_W'(BLINK_ON_FRAMES);
    localparam logic [CNT_W-1:0] OFF_VAL = CNT_W'(BLINK_OFF_FRAMES);

    game_flow_e state, next_state;

    logic vs_q, pause_q;
    logic tick, pause_edge;

    logic [NUM_PLAYERS-1:0] alive;
    logic [ALIVE_W-1:0]     alive_cnt;
    logic                   game_end;

    logic             start_go, in_go;
    logic             win_load, win_en, win_zero, win_one;
    logic             blink_load, blink_en, blink_one, blink_zero;
    logic [CNT_W-1:0] blink_val, blink_cnt;

    // Edge detectors: one-cycle pulse on each rising edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q    <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            vs_q    <= VGA_VS;
            pause_q <= pause_req;
        end
    end

    assign tick       = VGA_VS & ~vs_q;
    assign pause_edge = pause_req & ~pause_q;

    always_comb begin
        alive     = '0;
        alive_cnt = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            alive[i]  = |player_lives[i*LIFE_W +: LIFE_W];
            alive_cnt = alive_cnt + ALIVE_W'(alive[i]);
        end
    end

    assign game_end = (alive_cnt <= ALIVE_W'(1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT:       if (load_finish) next_state = START_PAGE;
            START_PAGE: if (start)       next_state = GAME_ON;
            GAME_ON: begin
                if (game_end)        next_state = GO_SHOW;
                else if (pause_edge) next_state = PAUSED;
            end
            PAUSED: begin
                if (restart)         next_state = START_PAGE;
                else if (pause_edge) next_state = GAME_ON;
            end
            GO_SHOW: begin
                // With the window exhausted the banner stays solid until restart.
                if (restart)                              next_state = START_PAGE;
                else if (tick && blink_one && !win_zero)  next_state = GO_HIDE;
            end
            GO_HIDE: begin
                if (restart)                next_state = START_PAGE;
                else if (tick && blink_one) next_state = GO_SHOW;
            end
            default:                        next_state = INIT;
        endcase
    end

    always_comb begin
        display_init   = 1'b0;
        load_startpage = 1'b0;
        load_map       = 1'b0;
        game_on        = 1'b0;
        paused         = 1'b0;
        game_over      = 1'b0;
        draw_gameover  = 1'b0;
        draw_cursor    = 1'b0;
        case (state)
            INIT:       display_init = 1'b1;
            START_PAGE: begin
                load_startpage = 1'b1;
                load_map       = 1'b1;
                draw_cursor    = 1'b1;
            end
            GAME_ON:    game_on = 1'b1;
            PAUSED: begin
                paused      = 1'b1;
                draw_cursor = 1'b1;
            end
            GO_SHOW: begin
                game_over     = 1'b1;
                draw_gameover = 1'b1;
                draw_cursor   = 1'b1;
            end
            GO_HIDE: begin
                game_over   = 1'b1;
                draw_cursor = 1'b1;
            end
            default:    display_init = 1'b0;
        endcase
    end

    assign flow_state = state;

    assign start_go = (state == START_PAGE) && start;
    assign in_go    = (state == GO_SHOW) || (state == GO_HIDE);

    assign win_load = start_go;
    assign win_en   = tick && in_go;

    // Blink reloads on entering play and on every show/hide flip.
    assign blink_load = start_go
                     || ((state == GO_SHOW) && (next_state == GO_HIDE))
                     || ((state == GO_HIDE) && (next_state == GO_SHOW));
    assign blink_val  = (state == GO_SHOW) ? OFF_VAL : ON_VAL;
    assign blink_en   = tick && in_go;

    frame_down_counter #(.W(CNT_W), .RESET_VAL(GO_VAL)) u_window (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (win_load),
        .load_value (GO_VAL),
        .enable     (win_en),
        .count      (frame_counter),
        .is_one     (win_one),
        .is_zero    (win_zero)
    );

    frame_down_counter #(.W(CNT_W), .RESET_VAL(ON_VAL)) u_blink (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (blink_load),
        .load_value (blink_val),
        .enable     (blink_en),
        .count      (blink_cnt),
        .is_one     (blink_one),
        .is_zero    (blink_zero)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            winner_onehot <= '0;
        end else if (start_go) begin
            winner_onehot <= '0;
        end else if ((state == GAME_ON) && game_end) begin
            winner_onehot <= alive;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboarded bench for game_flow_ctrl with a 2-player and a 4-player instance.
module tb_game_flow_ctrl;
    import game_flow_pkg::*;

    localparam logic [7:0] F_INIT  = 8'b1000_0000;
    localparam logic [7:0] F_START = 8'b0110_0001;
    localparam logic [7:0] F_ON    = 8'b0001_0000;
    localparam logic [7:0] F_PAUSE = 8'b0000_1001;
    localparam logic [7:0] F_SHOW  = 8'b0000_0111;
    localparam logic [7:0] F_HIDE  = 8'b0000_0101;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic VGA_VS = 1'b0, load_finish = 1'b0, start = 1'b0, restart = 1'b0, pause_req = 1'b0;
    logic [7:0]  lives2 = 8'h23;
    logic [15:0] lives4 = 16'h1111;

    logic d2_init, d2_sp, d2_map, d2_on, d2_pau, d2_go, d2_draw, d2_cur;
    logic d4_init, d4_sp, d4_map, d4_on, d4_pau, d4_go, d4_draw, d4_cur;
    logic [1:0] d2_win;
    logic [3:0] d4_win;
    logic [7:0] d2_fc, d4_fc;
    game_flow_e d2_st, d4_st;
    logic [7:0] flags2, flags4;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int checks = 0;
    int errors = 0;

    assign flags2 = {d2_init, d2_sp, d2_map, d2_on, d2_pau, d2_go, d2_draw, d2_cur};
    assign flags4 = {d4_init, d4_sp, d4_map, d4_on, d4_pau, d4_go, d4_draw, d4_cur};

    always #5 Clk = ~Clk;

    game_flow_ctrl #(.NUM_PLAYERS(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .load_finish(load_finish),
        .start(start), .restart(restart), .pause_req(pause_req), .player_lives(lives2),
        .display_init(d2_init), .load_startpage(d2_sp), .load_map(d2_map), .game_on(d2_on),
        .paused(d2_pau), .game_over(d2_go), .draw_gameover(d2_draw), .draw_cursor(d2_cur),
        .winner_onehot(d2_win), .frame_counter(d2_fc), .flow_state(d2_st)
    );

    game_flow_ctrl #(.NUM_PLAYERS(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .load_finish(load_finish),
        .start(start), .restart(restart), .pause_req(pause_req), .player_lives(lives4),
        .display_init(d4_init), .load_startpage(d4_sp), .load_map(d4_map), .game_on(d4_on),
        .paused(d4_pau), .game_over(d4_go), .draw_gameover(d4_draw), .draw_cursor(d4_cur),
        .winner_onehot(d4_win), .frame_counter(d4_fc), .flow_state(d4_st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_frame();
        VGA_VS = 1'b1;
        step();
        VGA_VS = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] exp_draw;
        // Reset
        step(); step();
        sb_push("rst_flags", F_INIT); sb_push("rst_win", 0); sb_push("rst_fc", 160);
        sb_pop(flags2); sb_pop(d2_win); sb_pop(d2_fc);
        Reset = 1'b0;
        step();
        sb_push("init_hold", F_INIT); sb_pop(flags2);

        // Test 1: load_finish pulse
        load_finish = 1'b1;
        sb_push("t1_startpage", F_START);
        step();
        load_finish = 1'b0;
        sb_pop(flags2);

        // Test 2: start, then player 1 dies
        start = 1'b1;
        sb_push("t2_game_on", F_ON); sb_push("t2_fc", 160); sb_push("t2_win0", 0);
        step();
        start = 1'b0;
        sb_pop(flags2); sb_pop(d2_fc); sb_pop(d2_win);
        sb_push("t2_stay_on", F_ON);
        step();
        sb_pop(flags2);
        lives2 = {4'd0, 4'd3};
        sb_push("t2_go_show", F_SHOW); sb_push("t2_winner", 2'b01);
        step();
        sb_pop(flags2); sb_pop(d2_win);
        lives2 = 8'h00;
        sb_push("t2_lives_ignored", 2'b01);
        step();
        sb_pop(d2_win);

        // Tests 3/4: blink window and saturation
        for (int t = 1; t <= 200; t++) begin
            exp_draw = (t >= 160) ? 32'd1 : ((((t / 16) % 2) == 0) ? 32'd1 : 32'd0);
            sb_push($sformatf("t3_draw_%0d", t), exp_draw);
            sb_push($sformatf("t3_fc_%0d", t), (t >= 160) ? 0 : 160 - t);
            sb_push($sformatf("t3_gameover_%0d", t), 1);
            tick_frame();
            sb_pop(d2_draw); sb_pop(d2_fc); sb_pop(d2_go);
        end
        restart = 1'b1;
        sb_push("t4_restart", F_START);
        step();
        restart = 1'b0;
        sb_pop(flags2);

        // Test 5: pause held, second rise, restart from pause
        lives2 = {4'd2, 4'd3};
        start = 1'b1;
        sb_push("t5_on", F_ON); sb_push("t5_fc_reload", 160);
        step();
        start = 1'b0;
        sb_pop(flags2); sb_pop(d2_fc);
        pause_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sb_push($sformatf("t5_held_%0d", i), F_PAUSE);
            step();
            sb_pop(flags2);
        end
        pause_req = 1'b0;
        sb_push("t5_release", F_PAUSE);
        step();
        sb_pop(flags2);
        pause_req = 1'b1;
        sb_push("t5_resume", F_ON);
        step();
        sb_pop(flags2);
        pause_req = 1'b0;
        step();
        pause_req = 1'b1;
        sb_push("t5_pause2", F_PAUSE);
        step();
        sb_pop(flags2);
        pause_req = 1'b0;
        restart = 1'b1;
        sb_push("t5_restart", F_START);
        step();
        restart = 1'b0;
        sb_pop(flags2);

        // Game end beats a pause edge in the same cycle
        start = 1'b1;
        step();
        start = 1'b0;
        lives2 = {4'd0, 4'd3};
        pause_req = 1'b1;
        sb_push("end_beats_pause", F_SHOW); sb_push("end_beats_win", 2'b01);
        step();
        sb_pop(flags2); sb_pop(d2_win);
        pause_req = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;

        // Both players out in the same cycle: draw
        lives2 = {4'd2, 4'd3};
        start = 1'b1;
        sb_push("draw_on", F_ON); sb_push("draw_win_clear", 0);
        step();
        start = 1'b0;
        sb_pop(flags2); sb_pop(d2_win);
        lives2 = 8'h00;
        sb_push("draw_show", F_SHOW); sb_push("draw_win", 0);
        step();
        sb_pop(flags2); sb_pop(d2_win);

        // Test 6: four players, then reset from GO_HIDE
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        lives4 = {4'd1, 4'd0, 4'd2, 4'd0};
        load_finish = 1'b1;
        step();
        load_finish = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        sb_push("t6_on", F_ON);
        step();
        sb_pop(flags4);
        lives4 = {4'd1, 4'd0, 4'd0, 4'd0};
        sb_push("t6_show", F_SHOW); sb_push("t6_winner", 4'b1000);
        step();
        sb_pop(flags4); sb_pop(d4_win);
        for (int t = 0; t < 16; t++) tick_frame();
        sb_push("t6_hide", F_HIDE); sb_push("t6_hide_fc", 144);
        sb_pop(flags4); sb_pop(d4_fc);
        Reset = 1'b1;
        sb_push("t6_rst_flags", F_INIT); sb_push("t6_rst_win", 0); sb_push("t6_rst_fc", 160);
        step();
        sb_pop(flags4); sb_pop(d4_win); sb_pop(d4_fc);
        Reset = 1'b0;

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
